// File: rtl/mips32_pkg.sv
// Shared constants and types for the MIPS32 program loader slice.
// Holds the loader FSM encoding, sync marker and memory geometry.
package mips32_pkg;

  localparam int MEM_DEPTH = 1024;
  localparam int CNT_W = 16;
  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam logic [5:0] OP_HLT = 6'h3f;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR_H,
    ST_ADDR_L,
    ST_CNT_H,
    ST_CNT_L,
    ST_DATA,
    ST_CSUM,
    ST_DRAIN,
    ST_START
  } ld_state_e;

endpackage

// File: rtl/mips32_prog_loader_word_assembler.sv
// Packs big-endian payload bytes into 32-bit words.
// word_valid_o fires combinationally with the fourth byte.
module prog_word_assembler (
  input  logic        clk1,
  input  logic        rst,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  logic [1:0]  cnt_q;
  logic [23:0] sh_q;

  assign word_valid_o = byte_valid_i && (cnt_q == 2'd3);
  assign word_o = {sh_q, byte_i};

  always_ff @(posedge clk1) begin
    if (rst) begin
      cnt_q <= 2'd0;
      sh_q <= 24'd0;
    end else if (byte_valid_i) begin
      cnt_q <= cnt_q + 2'd1;
      sh_q <= {sh_q[15:0], byte_i};
    end
  end

endmodule

// File: rtl/mips32_prog_loader.sv
// Framed byte-stream loader for MIPS32 memory.
// Writes words, verifies XOR checksum, then releases the CPU.
module mips32_prog_loader
  import mips32_pkg::*;
#(
  parameter int ADDR_W = $clog2(MEM_DEPTH),
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              cpu_start,
  output logic              busy,
  output logic              err_chk,
  output logic              err_range,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int SPAN_W = CNT_W + 1;
  localparam int DR_W = CNT_W + 2;
  localparam int WL_W = ADDR_W + 1;

  ld_state_e         state_q;
  logic [7:0]        addr_h_q;
  logic [ADDR_W-1:0] base_q;
  logic [7:0]        cnt_h_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [7:0]        csum_q;
  logic [DR_W-1:0]   drain_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic              cpu_hold_q;
  logic              cpu_start_q;
  logic              busy_q;
  logic              err_chk_q;
  logic              err_range_q;
  logic [WL_W-1:0]   words_loaded_q;

  logic              accept;
  logic              data_acc;
  logic              word_valid;
  logic [31:0]       word;
  logic [CNT_W-1:0]  cnt_w;
  logic [SPAN_W-1:0] span;
  logic              range_bad;
  logic              last_word;

  assign in_ready = (state_q != ST_START);
  assign accept = in_valid && in_ready;
  assign data_acc = accept && (state_q == ST_DATA);
  assign cnt_w = {cnt_h_q, in_data};
  // Wide sum so base+CNT == depth is legal and large CNT cannot wrap
  assign span = SPAN_W'(base_q) + SPAN_W'(cnt_w);
  assign range_bad = span > (SPAN_W'(1) << ADDR_W);
  assign last_word =
    (SPAN_W'(words_loaded_q) + SPAN_W'(1)) == SPAN_W'(cnt_q);

  prog_word_assembler u_asm (
    .clk1         (clk1),
    .rst          (rst),
    .byte_valid_i (data_acc),
    .byte_i       (in_data),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_h_q <= 8'd0;
      base_q <= '0;
      cnt_h_q <= 8'd0;
      cnt_q <= '0;
      csum_q <= 8'd0;
      drain_q <= '0;
      mem_we_q <= 1'b0;
      mem_addr_q <= '0;
      mem_wdata_q <= 32'd0;
      cpu_hold_q <= 1'b1;
      cpu_start_q <= 1'b0;
      busy_q <= 1'b0;
      err_chk_q <= 1'b0;
      err_range_q <= 1'b0;
      words_loaded_q <= '0;
    end else begin
      mem_we_q <= 1'b0;
      cpu_start_q <= 1'b0;
      if (word_valid) begin
        mem_we_q <= 1'b1;
        mem_addr_q <= base_q + words_loaded_q[ADDR_W-1:0];
        mem_wdata_q <= word;
        words_loaded_q <= words_loaded_q + WL_W'(1);
      end
      unique case (state_q)
        ST_IDLE: begin
          if (accept && in_data == SYNC_BYTE) begin
            state_q <= ST_ADDR_H;
            busy_q <= 1'b1;
            cpu_hold_q <= 1'b1;
            err_chk_q <= 1'b0;
            err_range_q <= 1'b0;
            words_loaded_q <= '0;
            csum_q <= 8'd0;
          end
        end
        ST_ADDR_H: begin
          if (accept) begin
            addr_h_q <= in_data;
            state_q <= ST_ADDR_L;
          end
        end
        ST_ADDR_L: begin
          if (accept) begin
            base_q <= ADDR_W'({addr_h_q, in_data});
            state_q <= ST_CNT_H;
          end
        end
        ST_CNT_H: begin
          if (accept) begin
            cnt_h_q <= in_data;
            state_q <= ST_CNT_L;
          end
        end
        ST_CNT_L: begin
          if (accept) begin
            cnt_q <= cnt_w;
            if (range_bad) begin
              err_range_q <= 1'b1;
              drain_q <= {cnt_w, 2'b00} + DR_W'(1);
              state_q <= ST_DRAIN;
            end else if (cnt_w == '0) begin
              state_q <= ST_CSUM;
            end else begin
              state_q <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (accept) begin
            csum_q <= csum_q ^ in_data;
            if (word_valid && last_word) begin
              state_q <= ST_CSUM;
            end
          end
        end
        ST_CSUM: begin
          if (accept) begin
            if (in_data == csum_q) begin
              cpu_start_q <= 1'b1;
              state_q <= ST_START;
            end else begin
              err_chk_q <= 1'b1;
              busy_q <= 1'b0;
              state_q <= ST_IDLE;
            end
          end
        end
        ST_DRAIN: begin
          if (accept) begin
            drain_q <= drain_q - DR_W'(1);
            if (drain_q == DR_W'(1)) begin
              busy_q <= 1'b0;
              state_q <= ST_IDLE;
            end
          end
        end
        ST_START: begin
          cpu_hold_q <= 1'b0;
          busy_q <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mem_we = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_hold = cpu_hold_q;
  assign cpu_start = cpu_start_q;
  assign busy = busy_q;
  assign err_chk = err_chk_q;
  assign err_range = err_range_q;
  assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_mips32_prog_loader.sv
// Directed frame-level bench for mips32_prog_loader.
module tb_mips32_prog_loader;

  localparam int AW = 10;

  logic          clk1 = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'd0;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          cpu_hold;
  logic          cpu_start;
  logic          busy;
  logic          err_chk;
  logic          err_range;
  logic [AW:0]   words_loaded;

  mips32_prog_loader #(.ADDR_W(AW), .SYNC_BYTE(8'hA5)) dut (
    .clk1         (clk1),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .cpu_hold     (cpu_hold),
    .cpu_start    (cpu_start),
    .busy         (busy),
    .err_chk      (err_chk),
    .err_range    (err_range),
    .words_loaded (words_loaded)
  );

  always #5 clk1 = ~clk1;

  typedef struct {
    logic [15:0] base;
    int          cnt;
    bit          prog;
    bit          bad;
    bit          gaps;
    bit          garbage;
    int          e_wr;
    bit          e_chk;
    bit          e_rng;
    int          e_st;
    bit          e_hold;
    int          e_wl;
  } vec_t;

  typedef struct {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } wr_t;

  vec_t tbl[8];
  logic [31:0] prog_w[8];
  wr_t wq[$];
  int starts;
  int n_chk = 0;
  int n_pass = 0;

  always @(negedge clk1) begin
    if (!rst) begin
      if (mem_we) wq.push_back('{mem_addr, mem_wdata});
      if (cpu_start) starts++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  function automatic logic [31:0] word_of(input vec_t v, input int i);
    if (v.prog) return prog_w[i];
    return {8'hA5, 8'(i), 8'h5A ^ 8'(i), v.base[7:0]};
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit acc;
    int k;
    if (gaps) begin
      k = $urandom_range(0, 2);
      for (int j = 0; j < k; j++) begin
        @(posedge clk1);
        #1;
      end
    end
    in_valid = 1'b1;
    in_data = b;
    acc = 1'b0;
    for (int t = 0; t < 20 && !acc; t++) begin
      acc = in_ready;
      @(posedge clk1);
      #1;
    end
    in_valid = 1'b0;
    if (!acc) begin
      n_chk++;
      $display("FAIL accept timeout: byte %h not taken, want taken", b);
    end
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    logic [7:0] cs;
    logic [31:0] w;
    logic [AW-1:0] ea;
    bit busy_last;
    int n;
    wq.delete();
    starts = 0;
    cs = 8'd0;
    if (v.garbage) begin
      send_byte(8'h00, 0);
      send_byte(8'hFF, 0);
      send_byte(8'h12, 0);
    end
    send_byte(8'hA5, v.gaps);
    send_byte(v.base[15:8], v.gaps);
    send_byte(v.base[7:0], v.gaps);
    send_byte(8'(v.cnt >> 8), v.gaps);
    send_byte(8'(v.cnt), v.gaps);
    for (int i = 0; i < v.cnt; i++) begin
      w = word_of(v, i);
      for (int b = 3; b >= 0; b--) begin
        cs = cs ^ w[8*b+:8];
        send_byte(w[8*b+:8], v.gaps);
      end
    end
    if (v.bad) cs = cs ^ 8'h01;
    busy_last = busy;
    send_byte(cs, v.gaps);
    repeat (4) @(posedge clk1);
    #1;
    chk({nm, " nwrites"}, wq.size(), v.e_wr);
    n = (wq.size() < v.e_wr) ? wq.size() : v.e_wr;
    for (int i = 0; i < n; i++) begin
      ea = v.base[AW-1:0] + AW'(i);
      chk($sformatf("%s wr%0d addr", nm, i), 32'(wq[i].a), 32'(ea));
      chk($sformatf("%s wr%0d data", nm, i), wq[i].d, word_of(v, i));
    end
    chk({nm, " busy before csum"}, 32'(busy_last), 1);
    chk({nm, " busy end"}, 32'(busy), 0);
    chk({nm, " in_ready"}, 32'(in_ready), 1);
    chk({nm, " err_chk"}, 32'(err_chk), 32'(v.e_chk));
    chk({nm, " err_range"}, 32'(err_range), 32'(v.e_rng));
    chk({nm, " starts"}, starts, v.e_st);
    chk({nm, " cpu_hold"}, 32'(cpu_hold), 32'(v.e_hold));
    chk({nm, " words_loaded"}, 32'(words_loaded), v.e_wl);
  endtask

  initial begin
    prog_w = '{32'h28010078, 32'h0c631800, 32'h20220000, 32'h0c631800,
               32'h2842002d, 32'h0c631800, 32'h24220001, 32'hfc000000};
    tbl[0] = '{16'h0000, 8, 1, 0, 0, 0, 8, 0, 0, 1, 0, 8};
    tbl[1] = '{16'h0000, 8, 1, 1, 0, 0, 8, 1, 0, 0, 1, 8};
    tbl[2] = '{16'd1020, 5, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0};
    tbl[3] = '{16'd1000, 3, 0, 0, 0, 0, 3, 0, 0, 1, 0, 3};
    tbl[4] = '{16'd1021, 3, 0, 0, 1, 0, 3, 0, 0, 1, 0, 3};
    tbl[5] = '{16'h0000, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0};
    tbl[6] = '{16'hFC05, 2, 0, 0, 0, 0, 2, 0, 0, 1, 0, 2};
    tbl[7] = '{16'd1023, 2, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0};

    repeat (3) @(posedge clk1);
    #1;
    chk("rst in_ready", 32'(in_ready), 1);
    chk("rst mem_we", 32'(mem_we), 0);
    chk("rst mem_addr", 32'(mem_addr), 0);
    chk("rst mem_wdata", mem_wdata, 0);
    chk("rst cpu_hold", 32'(cpu_hold), 1);
    chk("rst cpu_start", 32'(cpu_start), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst errs", {30'd0, err_chk, err_range}, 0);
    chk("rst words_loaded", 32'(words_loaded), 0);
    rst = 1'b0;
    @(posedge clk1);
    #1;

    for (int i = 0; i < 8; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    run_vec(tbl[5], "run cnt0");
    wq.delete();
    starts = 0;
    send_byte(8'hA5, 0);
    chk("rehold cpu_hold", 32'(cpu_hold), 1);
    chk("rehold busy", 32'(busy), 1);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    repeat (3) @(posedge clk1);
    #1;
    chk("rehold starts", starts, 1);
    chk("rehold cpu_hold end", 32'(cpu_hold), 0);
    chk("rehold nwrites", wq.size(), 0);

    wq.delete();
    send_byte(8'hA5, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk1);
    #1;
    rst = 1'b0;
    @(posedge clk1);
    #1;
    chk("midrst nwrites", wq.size(), 0);
    chk("midrst cpu_hold", 32'(cpu_hold), 1);
    chk("midrst busy", 32'(busy), 0);
    chk("midrst in_ready", 32'(in_ready), 1);
    chk("midrst words_loaded", 32'(words_loaded), 0);
    run_vec(tbl[0], "post rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
